// File: rtl/de10lite_qsys_pio_in_irq.sv
// Avalon-MM input PIO: synchronised input bus, per-bit edge capture with write-1-to-clear,
// and a maskable level interrupt (edge or level sourced).
module de10lite_qsys_pio_in_irq #(
  parameter int         WIDTH       = 32,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RESET_MODE  = 2'b00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_ANY   = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [1:0]       r_mode;
  logic             r_irq;
  logic [31:0]      r_readdata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = in_port;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_wdata  = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata};
  assign w_rise   = w_sync & ~r_prev;
  assign w_fall   = ~w_sync & r_prev;
  assign w_w1c    = (write && address == ADDR_EDGECAP) ? w_wdata : '0;

  always_comb begin
    w_ev = '0;
    case (r_mode)
      MODE_RISE: w_ev = w_rise;
      MODE_FALL: w_ev = w_fall;
      MODE_ANY:  w_ev = w_rise | w_fall;
      default:   w_ev = '0;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux = 32'(w_sync);
      ADDR_IRQMASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGECAP: w_rd_mux = 32'(r_cap);
      default:      w_rd_mux = {30'd0, r_mode};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_mode     <= RESET_MODE;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_prev <= w_sync;
      // Set is OR-ed in after the clear so a coincident event is never lost.
      r_cap  <= (r_cap & ~w_w1c) | w_ev;
      if (write && address == ADDR_IRQMASK) r_mask <= w_wdata;
      if (write && address == ADDR_CTRL)    r_mode <= writedata[1:0];
      if (r_mode == MODE_LEVEL) r_irq <= |(w_sync & r_mask);
      else                      r_irq <= |(r_cap & r_mask);
      if (read) r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_de10lite_qsys_pio_in_irq.sv
// Scoreboard bench for de10lite_qsys_pio_in_irq: a queue-based input-delay model predicts
// read data and irq; a negedge monitor pops and compares.
module tb_de10lite_qsys_pio_in_irq;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_port = '0;
  logic        irq;
  logic [31:0] readdata8;
  logic        irq8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  de10lite_qsys_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(SS), .RESET_MODE(2'b00)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq));

  de10lite_qsys_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(0), .RESET_MODE(2'b00)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata8), .in_port(in_port[7:0]), .irq(irq8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else
      $display("ok   %s: %h at %0t", name, act, $time);
  endtask

  // Reference model: s is in_port delayed SS clocks, p is s one clock older.
  logic [31:0] hq [$];
  logic [31:0] exp_q [$];
  logic [31:0] m_mask, m_cap;
  logic [1:0]  m_mode;
  logic        m_irq;
  bit          rd_pend;

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i <= SS; i++) hq.push_back(32'd0);
    exp_q.delete();
    m_mask = '0; m_cap = '0; m_mode = 2'b00; m_irq = 1'b0; rd_pend = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      logic [31:0] s, p, ev, w1c, rv;
      logic        irq_n;
      s = hq[hq.size()-SS];
      p = hq[hq.size()-SS-1];
      case (m_mode)
        2'b00:   ev = s & ~p;
        2'b01:   ev = ~s & p;
        2'b10:   ev = s ^ p;
        default: ev = '0;
      endcase
      irq_n = (m_mode == 2'b11) ? |(s & m_mask) : |(m_cap & m_mask);
      case (address)
        2'd0:    rv = s;
        2'd1:    rv = m_mask;
        2'd2:    rv = m_cap;
        default: rv = {30'd0, m_mode};
      endcase
      rd_pend = read;
      if (read) exp_q.push_back(rv);
      w1c = (write && address == 2'd2) ? writedata : '0;
      m_cap = (m_cap & ~w1c) | ev;
      if (write && address == 2'd1) m_mask = writedata;
      if (write && address == 2'd3) m_mode = writedata[1:0];
      m_irq = irq_n;
      hq.push_back(in_port);
      if (hq.size() > 8) void'(hq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      if (rd_pend) begin
        if (exp_q.size() == 0) check("read_q_empty", 32'd1, 32'd0);
        else check($sformatf("read a%0d", address), readdata, exp_q.pop_front());
        rd_pend = 0;
      end
    end
  end

  task automatic bus(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    read = r; write = w; address = a; writedata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(0, 0, 2'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    read = 0; write = 0; reset_n = 1'b0;
    #1;
    check("reset readdata", readdata, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset readdata8", readdata8, 32'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Input visible through the synchroniser
    in_port = 32'hA5A5_0F0F;
    for (int i = 0; i < SS + 3; i++) bus(1, 0, 2'd0, 32'd0);
    idle(1);
    check("dut8 data", readdata8, 32'h0000_000F);
    // Rising capture, irq, W1C
    in_port = 32'h0;
    bus(0, 1, 2'd3, 32'd0);
    bus(0, 1, 2'd1, 32'd1);
    idle(4);
    bus(0, 1, 2'd2, 32'hFFFF_FFFF);
    in_port = 32'h1;
    idle(5);
    bus(1, 0, 2'd2, 32'd0);
    bus(0, 1, 2'd2, 32'd1);
    idle(2);
    bus(1, 0, 2'd2, 32'd0);
    // Falling mode then any-edge on bit3
    bus(0, 1, 2'd3, 32'd1);
    bus(0, 1, 2'd1, 32'h8);
    in_port = 32'h8; idle(4);
    bus(0, 1, 2'd2, 32'hFFFF_FFFF);
    in_port = 32'h0; idle(4);
    bus(1, 0, 2'd2, 32'd0);
    in_port = 32'h8; idle(4);
    bus(1, 0, 2'd2, 32'd0);
    bus(0, 1, 2'd3, 32'd2);
    bus(0, 1, 2'd2, 32'hFFFF_FFFF);
    in_port = 32'h0; idle(1);
    in_port = 32'h8; idle(4);
    bus(1, 0, 2'd2, 32'd0);
    // Capture and W1C of bit5 on the same clock
    bus(0, 1, 2'd3, 32'd0);
    bus(0, 1, 2'd1, 32'h20);
    in_port = 32'h0; idle(4);
    bus(0, 1, 2'd2, 32'hFFFF_FFFF);
    in_port = 32'h20;
    bus(0, 0, 2'd0, 32'd0);
    bus(0, 1, 2'd2, 32'h20);
    bus(1, 0, 2'd2, 32'd0);
    // Level mode on bit4
    bus(0, 1, 2'd2, 32'hFFFF_FFFF);
    bus(0, 1, 2'd3, 32'd3);
    bus(0, 1, 2'd1, 32'h10);
    in_port = 32'h10; idle(5);
    in_port = 32'h0;  idle(5);
    bus(1, 0, 2'd2, 32'd0);
    bus(1, 0, 2'd3, 32'd0);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ (32'd1 << $urandom_range(0, 31));
      if (op < 3) bus(0, 1, 2'($urandom_range(1, 3)), $urandom);
      else if (op < 7) bus(1, 0, 2'($urandom_range(0, 3)), 32'd0);
      else idle(1);
    end
    // Narrow instance mask truncation
    bus(0, 1, 2'd1, 32'hFFFF_FFFF);
    bus(1, 0, 2'd1, 32'd0);
    idle(1);
    check("dut8 mask", readdata8, 32'h0000_00FF);
    // Reset in the middle of capture
    bus(0, 1, 2'd3, 32'd2);
    in_port = ~in_port; idle(4);
    do_reset();
    bus(1, 0, 2'd2, 32'd0);
    bus(1, 0, 2'd1, 32'd0);
    bus(1, 0, 2'd3, 32'd0);
    idle(3);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
